timer_device: RTL

Memory-mapped interval timer occupying one slot behind the data-side bridge; it is the responder to the Memory stage's bus accesses (address, write data, write enable, read data). It holds three word registers (CTRL, PRESET, COUNT), counts down from PRESET under a small state machine, and raises an interrupt request toward CP0. It supports a one-shot mode and an auto-reload mode.

---
 rtl/timer_device_pkg.sv | 30 +++
 rtl/timer_device_if.sv | 11 +
 rtl/timer_device.sv | 100 ++++++++++
 3 files changed

// File: rtl/timer_device_pkg.sv
// Shared definitions for the interval timer: FSM encodings, register offsets,
// CTRL bit positions and the bridge-side base address.
package timer_device_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0]  MODE_ONESHOT = 2'd0;
  localparam logic [1:0]  MODE_RELOAD  = 2'd1;
  localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_7F00;

  // Only MODE 1 reloads; the unused encodings 2 and 3 fall back to one-shot.
  function automatic logic is_reload(input logic [3:0] ctrl);
    return ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_device_if.sv
// Memory-stage bus toward the timer: word offset, write strobe, write data and
// combinational read data.
interface timer_device_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/timer_device.sv
// Interval timer with CTRL/PRESET/COUNT registers, one-shot and auto-reload
// modes, and an interrupt request masked by CTRL.IM.
module timer_device
  import timer_device_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  timer_device_if.slave  bus,
  output logic           irq
);

  timer_state_e state_q;
  logic [3:0]   ctrl_q;
  logic [31:0]  preset_q;
  logic [31:0]  count_q;
  logic         intr_q;

  logic wr_ctrl_s;
  logic wr_preset_s;
  logic en_s;
  logic reload_s;

  assign wr_ctrl_s   = bus.we && (bus.addr == TIMER_CTRL);
  assign wr_preset_s = bus.we && (bus.addr == TIMER_PRESET);
  assign en_s        = ctrl_q[CTRL_EN];
  assign reload_s    = is_reload(ctrl_q);

  assign irq = intr_q & ctrl_q[CTRL_IM];

  // Read mux: zero latency, reserved offset reads as zero.
  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      TIMER_CTRL:   bus.dout = {28'd0, ctrl_q};
      TIMER_PRESET: bus.dout = preset_q;
      TIMER_COUNT:  bus.dout = count_q;
      default:      bus.dout = 32'd0;
    endcase
  end

  // Countdown FSM plus bus writes; bus updates are placed last so they win
  // over same-cycle FSM effects on EN and intr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      intr_q   <= 1'b0;
    end else begin
      // In auto-reload mode intr is a single-cycle pulse.
      if (reload_s) begin
        intr_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (en_s) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_s) begin
            state_q <= ST_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q <= 32'd0;
            state_q <= ST_INT;
          end
        end
        ST_INT: begin
          intr_q <= 1'b1;
          if (reload_s) begin
            state_q <= en_s ? ST_LOAD : ST_IDLE;
          end else begin
            ctrl_q[CTRL_EN] <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (wr_ctrl_s) begin
        ctrl_q <= bus.din[3:0];
      end
      if (wr_preset_s) begin
        preset_q <= bus.din;
      end
      if (wr_ctrl_s || wr_preset_s) begin
        intr_q <= 1'b0;
      end
    end
  end

endmodule
